// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;
   localparam int DEPTH_DEF   = 4;
   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular DEPTH-entry buffer of fetched {pc, instr} pairs with flush.
module fetch_fifo import fetch_pkg::*; #(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_entry,
   input  logic                         pop,
   output fetch_entry_t                 head_entry,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // Power-of-two depth, so pointer wrap is the natural overflow.
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is data only; validity is tracked by count, so no reset needed.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[tail_q] <= push_entry;
   end

   assign head_entry = mem_q[head_q];
   assign count      = count_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC sequencer with credit-based request throttling and redirect flush.
module fetch_queue import fetch_pkg::*; #(
   parameter int          DEPTH    = DEPTH_DEF,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   input  logic        out_ready
);
   localparam int                CNT_W   = $clog2(DEPTH+1);
   localparam logic [CNT_W:0]    DEPTH_W = (CNT_W+1)'(DEPTH);

   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      inflight_pc_q, inflight_pc_d;
   logic             inflight_q, inflight_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   credit_used;
   logic             push, pop;
   fetch_entry_t     push_entry, head_entry;

   // Every outstanding fetch holds a slot, so the queue can never overflow.
   assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
   assign imem_req    = reset & ~redirect_valid & (credit_used < DEPTH_W);
   assign imem_addr   = fetch_pc_q;

   assign push       = inflight_q & ~redirect_valid;
   assign pop        = out_valid & out_ready & ~redirect_valid;
   assign push_entry = '{pc: inflight_pc_q, instr: imem_data};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = imem_req;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         inflight_d = 1'b0;
      end else if (imem_req) begin
         fetch_pc_d    = fetch_pc_q + 64'(INSTR_BYTES);
         inflight_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .count      (count)
   );

   assign out_valid = (count != '0);
   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;
endmodule
